// File: rtl/act_pkg.sv
// Shared types, widths and the saturating adder used by the activation pipeline.
package act_pkg;

  typedef enum logic [1:0] {
    ACT_PASS  = 2'd0,
    ACT_RELU  = 2'd1,
    ACT_LEAKY = 2'd2,
    ACT_CLIP  = 2'd3
  } act_mode_e;

  localparam int ACT_DW = 16;
  localparam int STAT_W = 32;

  typedef struct packed {
    logic signed [ACT_DW-1:0] x;
    logic                     neg;
    logic signed [ACT_DW-1:0] shifted;
  } s1_lane_t;

  function automatic logic [STAT_W-1:0] sat_add(input logic [STAT_W-1:0] a,
                                                input logic [STAT_W-1:0] b);
    logic [STAT_W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    if (sum[STAT_W]) begin
      sat_add = {STAT_W{1'b1}};
    end else begin
      sat_add = sum[STAT_W-1:0];
    end
  endfunction

endpackage

// File: rtl/act_lane.sv
// Per-lane stage-2 activation select/clamp; purely combinational.
module act_lane
  import act_pkg::*;
#(
  parameter int DATA_WIDTH = ACT_DW
) (
  input  act_mode_e                     mode,
  input  logic signed [DATA_WIDTH-1:0]  x,
  input  logic                          neg,
  input  logic signed [DATA_WIDTH-1:0]  shifted,
  input  logic signed [DATA_WIDTH-1:0]  clip_max,
  output logic signed [DATA_WIDTH-1:0]  y
);

  // Mode select; a negative clip bound forces every lane to zero.
  always_comb begin
    y = x;
    case (mode)
      ACT_PASS: y = x;
      ACT_RELU: begin
        if (neg) begin
          y = {DATA_WIDTH{1'b0}};
        end else begin
          y = x;
        end
      end
      ACT_LEAKY: begin
        if (neg) begin
          y = shifted;
        end else begin
          y = x;
        end
      end
      ACT_CLIP: begin
        if (neg || clip_max[DATA_WIDTH-1]) begin
          y = {DATA_WIDTH{1'b0}};
        end else if (x > clip_max) begin
          y = clip_max;
        end else begin
          y = x;
        end
      end
      default: y = x;
    endcase
  end

endmodule

// File: rtl/activation_pipe.sv
// Two-stage valid/ready activation pipeline (PASS/RELU/LEAKY/CLIP).
// Optional zero-clamp statistics counter enabled by the ACT_STATS_EN macro.
module activation_pipe
  import act_pkg::*;
#(
  parameter int DATA_WIDTH = ACT_DW,
  parameter int LENGTH     = 16,
  parameter int SHIFT_W    = 4
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 en,
  input  act_mode_e                            mode,
  input  logic [SHIFT_W-1:0]                   leak_shift,
  input  logic [DATA_WIDTH-1:0]                clip_max,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic [LENGTH-1:0][DATA_WIDTH-1:0]    In,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [LENGTH-1:0][DATA_WIDTH-1:0]    Out,
  output logic [STAT_W-1:0]                    zero_cnt,
  input  logic                                 stat_clr
);

  logic adv1_s;
  logic adv2_s;
  logic s1_valid_r;
  logic s2_valid_r;
  s1_lane_t [LENGTH-1:0]               s1_lane_r;
  act_mode_e                           s1_mode_r;
  logic signed [DATA_WIDTH-1:0]        s1_clip_r;
  logic [LENGTH-1:0][DATA_WIDTH-1:0]   lane_y_s;
  logic [LENGTH-1:0][DATA_WIDTH-1:0]   out_r;

  assign adv2_s    = en & (~s2_valid_r | out_ready);
  assign adv1_s    = en & (~s1_valid_r | adv2_s);
  assign in_ready  = adv1_s & ~reset;
  assign out_valid = s2_valid_r;
  assign Out       = out_r;

  // Stage 1: capture the beat together with its configuration and pre-shifted value.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_r <= 1'b0;
      s1_lane_r  <= {($bits(s1_lane_t)*LENGTH){1'b0}};
      s1_mode_r  <= ACT_PASS;
      s1_clip_r  <= {DATA_WIDTH{1'b0}};
    end else if (adv1_s) begin
      s1_valid_r <= in_valid;
      if (in_valid) begin
        s1_mode_r <= mode;
        s1_clip_r <= clip_max;
        for (int i = 0; i < LENGTH; i++) begin
          s1_lane_r[i].x       <= In[i];
          s1_lane_r[i].neg     <= In[i][DATA_WIDTH-1];
          s1_lane_r[i].shifted <= $signed(In[i]) >>> leak_shift;
        end
      end
    end
  end

  for (genvar g = 0; g < LENGTH; g++) begin : g_lane
    act_lane #(.DATA_WIDTH(DATA_WIDTH)) u_lane (
      .mode     (s1_mode_r),
      .x        (s1_lane_r[g].x),
      .neg      (s1_lane_r[g].neg),
      .shifted  (s1_lane_r[g].shifted),
      .clip_max (s1_clip_r),
      .y        (lane_y_s[g])
    );
  end

  // Stage 2: output register; bubbles moving forward leave the last data in place.
  always_ff @(posedge clk) begin
    if (reset) begin
      s2_valid_r <= 1'b0;
      out_r      <= {(LENGTH*DATA_WIDTH){1'b0}};
    end else if (adv2_s) begin
      s2_valid_r <= s1_valid_r;
      if (s1_valid_r) begin
        out_r <= lane_y_s;
      end
    end
  end

`ifdef ACT_STATS_EN
  localparam int ZC_W = $clog2(LENGTH + 1);

  logic [ZC_W-1:0]   beat_zero_s;
  logic [ZC_W-1:0]   s2_zero_r;
  logic [STAT_W-1:0] zero_cnt_r;

  // Lanes clamped to zero from a nonzero input in the beat entering stage 2.
  always_comb begin
    beat_zero_s = {ZC_W{1'b0}};
    for (int i = 0; i < LENGTH; i++) begin
      if ((lane_y_s[i] == {DATA_WIDTH{1'b0}}) && (s1_lane_r[i].x != {DATA_WIDTH{1'b0}})) begin
        beat_zero_s = beat_zero_s + ZC_W'(1);
      end else begin
        beat_zero_s = beat_zero_s;
      end
    end
  end

  // Per-beat clamp count travels alongside the output beat.
  always_ff @(posedge clk) begin
    if (reset) begin
      s2_zero_r <= {ZC_W{1'b0}};
    end else if (adv2_s && s1_valid_r) begin
      s2_zero_r <= beat_zero_s;
    end
  end

  // Counter adds on the retiring handshake; clear takes priority.
  always_ff @(posedge clk) begin
    if (reset) begin
      zero_cnt_r <= {STAT_W{1'b0}};
    end else if (stat_clr) begin
      zero_cnt_r <= {STAT_W{1'b0}};
    end else if (en && s2_valid_r && out_ready) begin
      zero_cnt_r <= sat_add(zero_cnt_r, STAT_W'(s2_zero_r));
    end
  end

  assign zero_cnt = zero_cnt_r;
`else
  logic unused_stat_clr_s;
  assign unused_stat_clr_s = stat_clr;
  assign zero_cnt = {STAT_W{1'b0}};
`endif

endmodule

// File: tb/tb_activation_pipe.sv
// Directed self-checking bench for activation_pipe.
`timescale 1ns/1ps
module tb_activation_pipe;
  import act_pkg::*;

  localparam int DW = 16;
  localparam int LN = 16;
  localparam int SW = 4;
  typedef logic [LN-1:0][DW-1:0] vec_t;

  logic clk = 1'b0;
  logic reset, en, in_valid, in_ready, out_valid, out_ready, stat_clr;
  act_mode_e mode;
  logic [SW-1:0] leak_shift;
  logic [DW-1:0] clip_max;
  vec_t din, dout;
  logic [STAT_W-1:0] zero_cnt;
  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  activation_pipe #(.DATA_WIDTH(DW), .LENGTH(LN), .SHIFT_W(SW)) dut (
    .clk(clk), .reset(reset), .en(en), .mode(mode), .leak_shift(leak_shift),
    .clip_max(clip_max), .in_valid(in_valid), .in_ready(in_ready), .In(din),
    .out_valid(out_valid), .out_ready(out_ready), .Out(dout),
    .zero_cnt(zero_cnt), .stat_clr(stat_clr)
  );

  function automatic vec_t mk4(input logic [15:0] a, input logic [15:0] b,
                               input logic [15:0] c, input logic [15:0] d);
    vec_t v;
    v = '0;
    v[3] = a; v[2] = b; v[1] = c; v[0] = d;
    return v;
  endfunction

  function automatic vec_t bp_vec(input int k);
    return mk4(16'h0A00 + 16'(k), 16'hFFF0 - 16'(k), 16'(k), 16'h1234);
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic set_beat(input act_mode_e m, input logic [SW-1:0] sh,
                          input logic [DW-1:0] cm, input vec_t v);
    mode = m; leak_shift = sh; clip_max = cm; din = v; in_valid = 1'b1;
  endtask

  // One beat through an empty pipe with out_ready high; reports what was seen.
  task automatic run_single(input act_mode_e m, input logic [SW-1:0] sh,
                            input logic [DW-1:0] cm, input vec_t v,
                            output logic v_early, output logic v_late, output vec_t o);
    tick();
    set_beat(m, sh, cm, v);
    tick();
    in_valid = 1'b0;
    @(negedge clk); v_early = out_valid;
    @(posedge clk);
    @(negedge clk); v_late = out_valid; o = dout;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1; en = 1'b1; in_valid = 1'b0; out_ready = 1'b1; stat_clr = 1'b0;
    mode = ACT_PASS; leak_shift = '0; clip_max = '0; din = '0;
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL rst_valid: got %b want 0", out_valid); else pass_cnt++;
    total_cnt++; if (dout !== vec_t'(0)) $display("FAIL rst_out: got %h want 0", dout); else pass_cnt++;
    total_cnt++; if (in_ready !== 1'b0) $display("FAIL rst_in_ready: got %b want 0", in_ready); else pass_cnt++;
    total_cnt++; if (zero_cnt !== 32'd0) $display("FAIL rst_zero_cnt: got %0d want 0", zero_cnt); else pass_cnt++;
    tick();
    reset = 1'b0;
    @(negedge clk);
    total_cnt++; if (in_ready !== 1'b1) $display("FAIL post_rst_in_ready: got %b want 1", in_ready); else pass_cnt++;
  endtask

  task automatic test_relu();
    logic ve, vl; vec_t o;
    run_single(ACT_RELU, 4'd0, 16'd0, mk4(16'h7FFF, 16'h8000, 16'h0000, 16'h0005), ve, vl, o);
    total_cnt++; if (ve !== 1'b0) $display("FAIL relu_early_valid: got %b want 0", ve); else pass_cnt++;
    total_cnt++; if (vl !== 1'b1) $display("FAIL relu_valid: got %b want 1", vl); else pass_cnt++;
    total_cnt++; if (o !== mk4(16'h7FFF, 16'h0000, 16'h0000, 16'h0005)) $display("FAIL relu_out: got %h", o); else pass_cnt++;
  endtask

  task automatic test_leaky();
    logic ve, vl; vec_t o;
    run_single(ACT_LEAKY, 4'd2, 16'd0, mk4(16'hFFF8, 16'hFFFF, 16'h000C, 16'h8000), ve, vl, o);
    total_cnt++; if (vl !== 1'b1) $display("FAIL leaky_valid: got %b want 1", vl); else pass_cnt++;
    total_cnt++; if (o !== mk4(16'hFFFE, 16'hFFFF, 16'h000C, 16'hE000)) $display("FAIL leaky_sh2: got %h", o); else pass_cnt++;
    run_single(ACT_LEAKY, 4'd0, 16'd0, mk4(16'h8000, 16'hFFF0, 16'h0001, 16'hFFFF), ve, vl, o);
    total_cnt++; if (o !== mk4(16'h8000, 16'hFFF0, 16'h0001, 16'hFFFF)) $display("FAIL leaky_sh0: got %h", o); else pass_cnt++;
    run_single(ACT_LEAKY, 4'd15, 16'd0, mk4(16'h8000, 16'hFFF0, 16'h0001, 16'hC000), ve, vl, o);
    total_cnt++; if (o !== mk4(16'hFFFF, 16'hFFFF, 16'h0001, 16'hFFFF)) $display("FAIL leaky_sh15: got %h", o); else pass_cnt++;
  endtask

  task automatic test_clip();
    logic ve, vl; vec_t o;
    run_single(ACT_CLIP, 4'd0, 16'd6, mk4(16'hFFFD, 16'h0004, 16'h0006, 16'h0064), ve, vl, o);
    total_cnt++; if (o !== mk4(16'h0000, 16'h0004, 16'h0006, 16'h0006)) $display("FAIL clip_6: got %h", o); else pass_cnt++;
    run_single(ACT_CLIP, 4'd0, 16'hFFFF, mk4(16'h0005, 16'h7FFF, 16'h0000, 16'hFFF0), ve, vl, o);
    total_cnt++; if (vl !== 1'b1) $display("FAIL clip_neg_valid: got %b want 1", vl); else pass_cnt++;
    total_cnt++; if (o !== vec_t'(0)) $display("FAIL clip_neg: got %h want 0", o); else pass_cnt++;
  endtask

  task automatic test_backpressure();
    int sent, recv, stall_block;
    sent = 0; recv = 0; stall_block = 0;
    tick();
    for (int c = 0; c < 30; c++) begin
      out_ready = !(c >= 2 && c <= 4);
      if (sent < 5) set_beat(ACT_PASS, 4'd0, 16'd0, bp_vec(sent));
      else in_valid = 1'b0;
      @(negedge clk);
      if (c >= 2 && c <= 4 && in_ready == 1'b0 && sent == 2) stall_block++;
      if (out_valid && out_ready) begin
        total_cnt++;
        if (recv >= 5 || dout !== bp_vec(recv)) $display("FAIL bp_beat%0d: got %h want %h", recv, dout, bp_vec(recv));
        else pass_cnt++;
        recv++;
      end
      if (in_valid && in_ready) sent++;
      tick();
    end
    total_cnt++; if (stall_block !== 3) $display("FAIL bp_in_ready_stall: got %0d stalled cycles want 3", stall_block); else pass_cnt++;
    total_cnt++; if (recv !== 5) $display("FAIL bp_count: got %0d beats want 5", recv); else pass_cnt++;
    out_ready = 1'b1;
  endtask

  task automatic test_mode_switch();
    vec_t v, exp_v [3];
    act_mode_e ms [3];
    int sent, recv;
    v = mk4(16'hFFFC, 16'h0007, 16'hFFFF, 16'h0000);
    ms[0] = ACT_PASS; ms[1] = ACT_RELU; ms[2] = ACT_LEAKY;
    exp_v[0] = mk4(16'hFFFC, 16'h0007, 16'hFFFF, 16'h0000);
    exp_v[1] = mk4(16'h0000, 16'h0007, 16'h0000, 16'h0000);
    exp_v[2] = mk4(16'hFFFE, 16'h0007, 16'hFFFF, 16'h0000);
    sent = 0; recv = 0;
    out_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      if (sent < 3) set_beat(ms[sent], 4'd1, 16'd0, v);
      else in_valid = 1'b0;
      @(negedge clk);
      if (out_valid && out_ready) begin
        total_cnt++;
        if (recv >= 3 || dout !== exp_v[recv]) $display("FAIL mode_sw_beat%0d: got %h", recv, dout);
        else pass_cnt++;
        recv++;
      end
      if (in_valid && in_ready) sent++;
      tick();
    end
    total_cnt++; if (recv !== 3) $display("FAIL mode_sw_count: got %0d want 3", recv); else pass_cnt++;
  endtask

  task automatic test_enable();
    vec_t ve;
    ve = mk4(16'h0101, 16'h0202, 16'h0303, 16'h0404);
    out_ready = 1'b1;
    tick();
    set_beat(ACT_PASS, 4'd0, 16'd0, ve);
    tick();
    in_valid = 1'b0;
    tick();
    en = 1'b0;
    set_beat(ACT_PASS, 4'd0, 16'd0, mk4(16'h0BAD, 16'h0BAD, 16'h0BAD, 16'h0BAD));
    @(negedge clk);
    total_cnt++; if (in_ready !== 1'b0) $display("FAIL en0_in_ready: got %b want 0", in_ready); else pass_cnt++;
    tick();
    @(negedge clk);
    total_cnt++; if (out_valid !== 1'b1) $display("FAIL en0_hold_valid: got %b want 1", out_valid); else pass_cnt++;
    total_cnt++; if (dout !== ve) $display("FAIL en0_hold_out: got %h want %h", dout, ve); else pass_cnt++;
    tick();
    en = 1'b1; in_valid = 1'b0;
    tick();
    @(negedge clk);
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL en0_no_capture: got %b want 0", out_valid); else pass_cnt++;
  endtask

  task automatic test_reset_midstream();
    out_ready = 1'b0;
    tick();
    set_beat(ACT_PASS, 4'd0, 16'd0, mk4(16'h1111, 16'h1111, 16'h1111, 16'h1111));
    tick();
    set_beat(ACT_PASS, 4'd0, 16'd0, mk4(16'h2222, 16'h2222, 16'h2222, 16'h2222));
    tick();
    in_valid = 1'b0;
    reset = 1'b1;
    tick();
    @(negedge clk);
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL midrst_valid: got %b want 0", out_valid); else pass_cnt++;
    total_cnt++; if (dout !== vec_t'(0)) $display("FAIL midrst_out: got %h want 0", dout); else pass_cnt++;
    reset = 1'b0; out_ready = 1'b1;
    tick(); tick();
    @(negedge clk);
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL midrst_drop: got %b want 0", out_valid); else pass_cnt++;
  endtask

  task automatic test_stats();
    logic [STAT_W-1:0] exp_cnt;
`ifdef ACT_STATS_EN
    exp_cnt = 32'd6;
`else
    exp_cnt = 32'd0;
`endif
    out_ready = 1'b1;
    tick();
    stat_clr = 1'b1;
    tick();
    stat_clr = 1'b0;
    @(negedge clk);
    total_cnt++; if (zero_cnt !== 32'd0) $display("FAIL stat_clr_init: got %0d want 0", zero_cnt); else pass_cnt++;
    tick();
    for (int k = 0; k < 3; k++) begin
      set_beat(ACT_RELU, 4'd0, 16'd0, mk4(16'hFFFF, 16'hFFFE, 16'h0000, 16'h0003));
      tick();
    end
    in_valid = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    @(negedge clk);
    total_cnt++; if (dout !== mk4(16'h0000, 16'h0000, 16'h0000, 16'h0003)) $display("FAIL stat_relu_out: got %h", dout); else pass_cnt++;
    total_cnt++; if (zero_cnt !== exp_cnt) $display("FAIL stat_count: got %0d want %0d", zero_cnt, exp_cnt); else pass_cnt++;
    tick();
    stat_clr = 1'b1;
    tick();
    stat_clr = 1'b0;
    @(negedge clk);
    total_cnt++; if (zero_cnt !== 32'd0) $display("FAIL stat_clr: got %0d want 0", zero_cnt); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_relu();
    test_leaky();
    test_clip();
    test_backpressure();
    test_mode_switch();
    test_enable();
    test_reset_midstream();
    test_stats();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
